// File: rtl/y_upd_pkg.sv
// rtl/y_upd_pkg.sv - state encoding and datapath select constants for the Y-diagonal update sequencer
package y_upd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ADD,
        ST_SUB,
        ST_WRITE
    } upd_state_t;

    localparam logic [1:0] SEL_NEW  = 2'b00;
    localparam logic [1:0] SEL_OLD  = 2'b11;
    localparam logic [1:0] SEL_ZERO = 2'b01;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Result register recirculates through the adder with a zero operand, so it holds its value.
    localparam logic [1:0] IDLE_SEL_OLD_OR_NEW  = SEL_ZERO;
    localparam logic       IDLE_SEL_DIAG_OR_SUM = 1'b1;
    localparam logic       IDLE_SEL_MODE        = MODE_ADD;

endpackage

// File: rtl/y_diag_update_ctrl.sv
// rtl/y_diag_update_ctrl.sv - batch sequencer for the Y-diagonal addsub datapath; Y_UPD_NO_OLD_EN adds upd_no_old (skip SUB)
module y_diag_update_ctrl
    import y_upd_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_updates,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_remove,
`ifdef Y_UPD_NO_OLD_EN
    input  logic             upd_no_old,
`endif
    output logic             opnd_hold,
    output logic [1:0]       sel_old_or_new,
    output logic             sel_diag_or_sum,
    output logic             sel_mode_addsub,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic             busy,
    output logic             done
);

    upd_state_t       state_q;
    upd_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             remove_q;
    logic             no_old_q;
    logic             zero_done_q;
    logic             accept;
    logic             last;

    assign accept = upd_valid && upd_ready;
    assign last   = (cnt_q == CNT_W'(1));
    assign busy   = (state_q != ST_IDLE);
    assign wr_idx = idx_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && (n_updates != '0)) state_d = ST_ACCEPT;
            ST_ACCEPT: if (accept) state_d = ST_ADD;
            ST_ADD:    state_d = no_old_q ? ST_WRITE : ST_SUB;
            ST_SUB:    state_d = ST_WRITE;
            ST_WRITE: begin
                if (last)        state_d = ST_IDLE;
                else if (accept) state_d = ST_ADD;
                else             state_d = ST_ACCEPT;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        upd_ready       = 1'b0;
        opnd_hold       = 1'b0;
        sel_old_or_new  = IDLE_SEL_OLD_OR_NEW;
        sel_diag_or_sum = IDLE_SEL_DIAG_OR_SUM;
        sel_mode_addsub = IDLE_SEL_MODE;
        wr_en           = 1'b0;
        done            = zero_done_q;
        case (state_q)
            ST_ACCEPT: upd_ready = 1'b1;
            ST_ADD: begin
                sel_diag_or_sum = 1'b0;
                sel_old_or_new  = SEL_NEW;
                sel_mode_addsub = remove_q ? MODE_SUB : MODE_ADD;
                opnd_hold       = 1'b1;
            end
            ST_SUB: begin
                sel_diag_or_sum = 1'b1;
                sel_old_or_new  = SEL_OLD;
                sel_mode_addsub = remove_q ? MODE_ADD : MODE_SUB;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                // The last write completes the batch; otherwise the next request may be taken now.
                if (last) done = 1'b1;
                else      upd_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            remove_q    <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= (state_q == ST_IDLE) && start && (n_updates == '0);
            if ((state_q == ST_IDLE) && start) begin
                cnt_q <= n_updates;
            end else if (state_q == ST_WRITE) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (accept) begin
                idx_q    <= upd_idx;
                remove_q <= upd_remove;
            end
        end
    end

`ifdef Y_UPD_NO_OLD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            no_old_q <= 1'b0;
        end else if (accept) begin
            no_old_q <= upd_no_old;
        end
    end
`else
    assign no_old_q = 1'b0;
`endif

endmodule

// File: tb/tb_y_diag_update_ctrl.sv
// tb/tb_y_diag_update_ctrl.sv - self-checking bench with behavioural datapath and schedule-based reference model
module tb_y_diag_update_ctrl;

    localparam int IDX_W = 6;
    localparam int CNT_W = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_updates = '0;
    logic             upd_valid = 1'b0;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_remove = 1'b0;
    logic             opnd_hold;
    logic [1:0]       sel_old_or_new;
    logic             sel_diag_or_sum;
    logic             sel_mode_addsub;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             busy;
    logic             done;

    logic [47:0] y_diag = '0;
    logic [47:0] y_new = '0;
    logic [47:0] y_old = '0;
    logic [47:0] diag_r, new_r, old_r, y_new_diag, dp_in1, dp_in2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    y_diag_update_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .n_updates       (n_updates),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_idx         (upd_idx),
        .upd_remove      (upd_remove),
`ifdef Y_UPD_NO_OLD_EN
        .upd_no_old      (1'b0),
`endif
        .opnd_hold       (opnd_hold),
        .sel_old_or_new  (sel_old_or_new),
        .sel_diag_or_sum (sel_diag_or_sum),
        .sel_mode_addsub (sel_mode_addsub),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .busy            (busy),
        .done            (done)
    );

    // Datapath: operand registers, in1/in2 muxes, addsub, result register.
    always_comb begin
        dp_in1 = sel_diag_or_sum ? y_new_diag : diag_r;
        case (sel_old_or_new)
            2'b00:   dp_in2 = new_r;
            2'b11:   dp_in2 = old_r;
            default: dp_in2 = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            diag_r     <= '0;
            new_r      <= '0;
            old_r      <= '0;
            y_new_diag <= '0;
        end else begin
            if (upd_valid && upd_ready) begin
                diag_r <= y_diag;
                new_r  <= y_new;
                old_r  <= y_old;
            end
            y_new_diag <= sel_mode_addsub ? (dp_in1 - dp_in2) : (dp_in1 + dp_in2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a batch is a list of scheduled writes, each due 3 cycles after its acceptance.
    typedef struct {
        int               cyc;
        logic [IDX_W-1:0] idx;
        logic [47:0]      val;
        bit               last;
    } wr_t;

    wr_t         wq[$];
    int          cyc = 0;
    bit          m_active = 0;
    int          m_left = 0;
    int          m_ready_from = 0;
    int          m_hold_cyc = -1;
    int          zdone_cyc = -1;
    logic [47:0] m_result = '0;

    always @(negedge clock) begin
        bit  exp_ready;
        bit  exp_busy;
        bit  wr_due;
        bit  exp_done;
        wr_t w;
        if (!reset) begin
            chk("rst_upd_ready", upd_ready, 0);
            chk("rst_opnd_hold", opnd_hold, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_wr_idx", wr_idx, 0);
            chk("rst_selects", {sel_old_or_new, sel_diag_or_sum, sel_mode_addsub}, 4'b0110);
            wq.delete();
            m_active   = 0;
            m_left     = 0;
            m_hold_cyc = -1;
            zdone_cyc  = -1;
            m_result   = '0;
        end else begin
            wr_due    = (wq.size() != 0) && (wq[0].cyc == cyc);
            exp_busy  = m_active;
            exp_ready = m_active && (m_left > 0) && (cyc >= m_ready_from);
            exp_done  = (wr_due && wq[0].last) || (zdone_cyc == cyc);
            chk("upd_ready", upd_ready, exp_ready);
            chk("wr_en", wr_en, wr_due);
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("opnd_hold", opnd_hold, (cyc == m_hold_cyc));
            chk("sel_legal", (sel_old_or_new == 2'b10), 0);
            if (wr_due) begin
                chk("wr_idx", wr_idx, wq[0].idx);
                chk("wr_result", y_new_diag, wq[0].val);
            end
            if (!exp_busy) begin
                chk("idle_result_hold", y_new_diag, m_result);
                chk("idle_selects", {sel_old_or_new, sel_diag_or_sum, sel_mode_addsub}, 4'b0110);
            end
            if (wr_due) begin
                w = wq.pop_front();
                m_result = w.val;
                if (w.last) m_active = 0;
            end
            if (exp_ready && upd_valid) begin
                w.cyc  = cyc + 3;
                w.idx  = upd_idx;
                w.val  = upd_remove ? (y_diag - y_new + y_old) : (y_diag + y_new - y_old);
                w.last = (m_left == 1);
                wq.push_back(w);
                m_left--;
                m_ready_from = cyc + 3;
                m_hold_cyc   = cyc + 1;
            end
            if (start && !exp_busy) begin
                if (n_updates == 0) begin
                    zdone_cyc = cyc + 1;
                end else begin
                    m_active     = 1;
                    m_left       = int'(n_updates);
                    m_ready_from = cyc + 1;
                end
            end
        end
        cyc++;
    end

    task automatic wait_handshake(input string tag);
        bit hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clock);
            hs = upd_ready && upd_valid;
            @(posedge clock);
            #1;
        end
        if (!hs) chk({tag, "_handshake_timeout"}, 0, 1);
    endtask

    task automatic run_single(input logic [IDX_W-1:0] idx, input logic rm, input logic [47:0] d,
                              input logic [47:0] n, input logic [47:0] o, input logic [47:0] expv,
                              input string tag);
        int k = 0;
        start = 1'b1;
        n_updates = CNT_W'(1);
        @(posedge clock);
        #1;
        start = 1'b0;
        upd_valid = 1'b1;
        upd_idx = idx;
        upd_remove = rm;
        y_diag = d;
        y_new = n;
        y_old = o;
        wait_handshake(tag);
        upd_valid = 1'b0;
        while (k < 8) begin
            @(negedge clock);
            k++;
            if (wr_en) break;
        end
        chk({tag, "_latency"}, k, 3);
        chk({tag, "_result"}, y_new_diag, expv);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_wr_idx"}, wr_idx, idx);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr_count;
        int last_wr;
        int done_at;

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        run_single(6'd5, 1'b0, 48'd100, 48'd7, 48'd3, 48'd104, "single_add");
        run_single(6'd12, 1'b1, 48'd100, 48'd7, 48'd3, 48'd96, "single_remove");

        // Three requests with upd_valid held high: one write every third cycle.
        start = 1'b1;
        n_updates = CNT_W'(3);
        @(posedge clock);
        #1;
        start = 1'b0;
        upd_valid = 1'b1;
        upd_idx = 6'd9;
        upd_remove = 1'b0;
        y_diag = 48'd1000;
        y_new = 48'd50;
        y_old = 48'd20;
        wr_count = 0;
        last_wr = -1;
        done_at = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (wr_en) begin
                wr_count++;
                if (last_wr >= 0) chk("n3_gap", i - last_wr, 3);
                last_wr = i;
                chk("n3_value", y_new_diag, 48'd1030);
                if (done) done_at = wr_count;
            end
        end
        @(posedge clock);
        #1 upd_valid = 1'b0;
        chk("n3_writes", wr_count, 3);
        chk("n3_done_on", done_at, 3);

        // Empty batch.
        start = 1'b1;
        n_updates = '0;
        @(negedge clock);
        chk("n0_done_early", done, 0);
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("n0_done", done, 1);
        chk("n0_ready", upd_ready, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("n0_done_pulse", done, 0);
        @(posedge clock);
        #1;

        // Abort in SUB.
        start = 1'b1;
        n_updates = CNT_W'(2);
        @(posedge clock);
        #1;
        start = 1'b0;
        upd_valid = 1'b1;
        upd_idx = 6'd3;
        y_diag = 48'd500;
        y_new = 48'd5;
        y_old = 48'd1;
        wait_handshake("abort");
        upd_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_no_wr", wr_en, 0);
            chk("abort_no_done", done, 0);
        end
        @(posedge clock);
        #1;
        run_single(6'd33, 1'b0, 48'd100, 48'd7, 48'd3, 48'd104, "post_abort");

        // Random traffic, including start pulses while busy and upd_valid while idle.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 7) == 0);
            n_updates = CNT_W'($urandom_range(0, 4));
            upd_valid = ($urandom_range(0, 2) != 0);
            upd_idx = IDX_W'($urandom);
            upd_remove = 1'($urandom_range(0, 1));
            y_diag = {16'($urandom), 32'($urandom)};
            y_new = {16'($urandom), 32'($urandom)};
            y_old = {16'($urandom), 32'($urandom)};
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        upd_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
